ring_router_vc: RTL

Parametrised unidirectional ring router with per-VC input buffering, NI injection and ejection, round-robin arbitration and dateline VC promotion. It is the next-generation replacement for the fixed 8-bit, 2-VC ring router node. One instance sits at every ring stop between the upstream link, the downstream link and the local network interface (NI).

---
 rtl/ring_noc_pkg.sv | 38 +++
 rtl/ring_router_vc_if.sv | 36 +++
 rtl/ring_vc_fifo.sv | 51 +++++
 rtl/ring_router_vc.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/ring_noc_pkg.sv
// Shared helpers for the ring router: dest extraction, dateline VC promotion
// and a round-robin grant usable for any requester count up to MAX_REQ.
package ring_noc_pkg;

    localparam int unsigned MAX_REQ    = 16;
    localparam int unsigned MAX_FLIT_W = 64;

    function automatic int unsigned flit_dest(logic [MAX_FLIT_W-1:0] flit,
                                              int unsigned flit_w, int unsigned node_w);
        logic [MAX_FLIT_W-1:0] mask;
        mask = (64'd1 << node_w) - 64'd1;
        return 32'((flit >> (flit_w - node_w)) & mask);
    endfunction

    // The highest-numbered node is the dateline: flits crossing it climb one VC.
    function automatic int unsigned promote_vc(int unsigned vc, int unsigned node,
                                               int unsigned node_w, int unsigned num_vc);
        if (node == (32'd1 << node_w) - 32'd1) begin
            return (vc + 32'd1 < num_vc) ? vc + 32'd1 : num_vc - 32'd1;
        end
        return vc;
    endfunction

    function automatic logic [MAX_REQ-1:0] rr_grant(logic [MAX_REQ-1:0] req,
                                                    int unsigned ptr, int unsigned n);
        logic [MAX_REQ-1:0] gnt;
        int unsigned        idx;
        gnt = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (i < n) begin
                idx = (ptr + i) % n;
                if (gnt == '0 && req[idx]) gnt[idx] = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/ring_router_vc_if.sv
// Handshake bundle between a ring stop and its upstream/downstream links and NI.
interface ring_router_vc_if #(
    parameter int unsigned FLIT_W = 8,
    parameter int unsigned NUM_VC = 2
);
    localparam int unsigned VC_W = $clog2(NUM_VC);

    logic              up_valid;
    logic [VC_W-1:0]   up_vc;
    logic [FLIT_W-1:0] up_flit;
    logic [NUM_VC-1:0] up_ready;
    logic              ni_in_valid;
    logic [FLIT_W-1:0] ni_in_flit;
    logic              ni_in_ready;
    logic              down_valid;
    logic [VC_W-1:0]   down_vc;
    logic [FLIT_W-1:0] down_flit;
    logic [NUM_VC-1:0] down_ready;
    logic              ni_out_valid;
    logic [FLIT_W-1:0] ni_out_flit;
    logic              ni_out_ready;
    logic              free;
    logic              hold;

    modport master (
        output up_valid, up_vc, up_flit, ni_in_valid, ni_in_flit, down_ready, ni_out_ready,
        input  up_ready, ni_in_ready, down_valid, down_vc, down_flit, ni_out_valid,
               ni_out_flit, free, hold
    );

    modport slave (
        input  up_valid, up_vc, up_flit, ni_in_valid, ni_in_flit, down_ready, ni_out_ready,
        output up_ready, ni_in_ready, down_valid, down_vc, down_flit, ni_out_valid,
               ni_out_flit, free, hold
    );
endinterface

// File: rtl/ring_vc_fifo.sv
// Single-clock FIFO with registered occupancy; full/empty derive from the count.
module ring_vc_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) count_d = count_q + 1'b1;
        if (do_pop && !do_push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/ring_router_vc.sv
// Ring stop: per-VC input FIFOs plus NI injection FIFO, round-robin ejection and
// forwarding arbiters, dateline VC promotion on the highest-numbered node.
module ring_router_vc
    import ring_noc_pkg::*;
#(
    parameter int unsigned FLIT_W   = 8,
    parameter int unsigned NODE_W   = 2,
    parameter int unsigned NUM_VC   = 2,
    parameter int unsigned VC_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NODE_W-1:0]  current_node,
    ring_router_vc_if.slave    bus
);
    localparam int unsigned VC_W  = $clog2(NUM_VC);
    localparam int unsigned NREQ  = NUM_VC + 1;
    localparam int unsigned CNT_W = $clog2(VC_DEPTH) + 1;
    localparam int unsigned EP_W  = $clog2(NUM_VC);
    localparam int unsigned FP_W  = $clog2(NREQ);

    logic [NUM_VC-1:0] vc_push, vc_pop, vc_full, vc_empty;
    logic [FLIT_W-1:0] vc_head [NUM_VC];
    logic [CNT_W-1:0]  vc_count [NUM_VC];
    logic              inj_push, inj_pop, inj_full, inj_empty;
    logic [FLIT_W-1:0] inj_head;
    logic [CNT_W-1:0]  inj_count;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        assign vc_push[v] = bus.up_valid && (bus.up_vc == VC_W'(v)) && !vc_full[v];
        ring_vc_fifo #(.WIDTH(FLIT_W), .DEPTH(VC_DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (vc_push[v]),
            .din   (bus.up_flit),
            .pop   (vc_pop[v]),
            .dout  (vc_head[v]),
            .full  (vc_full[v]),
            .empty (vc_empty[v]),
            .count (vc_count[v])
        );
    end

    assign inj_push = bus.ni_in_valid && !inj_full;

    ring_vc_fifo #(.WIDTH(FLIT_W), .DEPTH(VC_DEPTH)) u_inj_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inj_push),
        .din   (bus.ni_in_flit),
        .pop   (inj_pop),
        .dout  (inj_head),
        .full  (inj_full),
        .empty (inj_empty),
        .count (inj_count)
    );

    logic [NUM_VC-1:0] ej_req, ej_gnt;
    logic [NREQ-1:0]   fw_elig, fw_gnt;
    logic [VC_W-1:0]   out_vc [NREQ];
    logic [EP_W-1:0]   ej_ptr_q, ej_ptr_d, ej_idx;
    logic [FP_W-1:0]   fw_ptr_q, fw_ptr_d, fw_idx;
    logic [FLIT_W-1:0] ej_flit, fw_flit;
    logic [VC_W-1:0]   fw_vc;
    logic              ej_done, free_c;

    // Eligibility already folds in the downstream ready of the outgoing VC.
    always_comb begin
        ej_req  = '0;
        fw_elig = '0;
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            out_vc[v] = VC_W'(promote_vc(v, 32'(current_node), NODE_W, NUM_VC));
            if (!vc_empty[v]) begin
                if (NODE_W'(flit_dest(MAX_FLIT_W'(vc_head[v]), FLIT_W, NODE_W)) == current_node)
                    ej_req[v] = 1'b1;
                else
                    fw_elig[v] = bus.down_ready[out_vc[v]];
            end
        end
        out_vc[NUM_VC]  = VC_W'(promote_vc(32'd0, 32'(current_node), NODE_W, NUM_VC));
        fw_elig[NUM_VC] = !inj_empty && bus.down_ready[out_vc[NUM_VC]];
    end

    assign ej_gnt  = NUM_VC'(rr_grant(MAX_REQ'(ej_req), 32'(ej_ptr_q), NUM_VC));
    assign fw_gnt  = NREQ'(rr_grant(MAX_REQ'(fw_elig), 32'(fw_ptr_q), NREQ));
    assign ej_done = (|ej_req) && bus.ni_out_ready;

    always_comb begin
        ej_flit = '0;
        ej_idx  = '0;
        fw_flit = '0;
        fw_vc   = '0;
        fw_idx  = '0;
        vc_pop  = '0;
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            if (ej_gnt[v]) begin
                ej_flit = vc_head[v];
                ej_idx  = EP_W'(v);
            end
            if (fw_gnt[v]) begin
                fw_flit = vc_head[v];
                fw_vc   = out_vc[v];
                fw_idx  = FP_W'(v);
            end
            vc_pop[v] = (ej_gnt[v] && bus.ni_out_ready) || fw_gnt[v];
        end
        if (fw_gnt[NUM_VC]) begin
            fw_flit = inj_head;
            fw_vc   = out_vc[NUM_VC];
            fw_idx  = FP_W'(NUM_VC);
        end
        inj_pop = fw_gnt[NUM_VC];
    end

    always_comb begin
        ej_ptr_d = ej_ptr_q;
        fw_ptr_d = fw_ptr_q;
        if (ej_done) ej_ptr_d = (ej_idx == EP_W'(NUM_VC - 1)) ? '0 : ej_idx + 1'b1;
        if (|fw_elig) fw_ptr_d = (fw_idx == FP_W'(NREQ - 1)) ? '0 : fw_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ej_ptr_q <= '0;
            fw_ptr_q <= '0;
        end else begin
            ej_ptr_q <= ej_ptr_d;
            fw_ptr_q <= fw_ptr_d;
        end
    end

    always_comb begin
        free_c = (inj_count == '0);
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            if (vc_count[v] != '0) free_c = 1'b0;
        end
    end

    assign bus.up_ready     = ~vc_full;
    assign bus.ni_in_ready  = !inj_full;
    assign bus.down_valid   = |fw_elig;
    assign bus.down_vc      = fw_vc;
    assign bus.down_flit    = fw_flit;
    assign bus.ni_out_valid = |ej_req;
    assign bus.ni_out_flit  = ej_flit;
    assign bus.free         = free_c;
    assign bus.hold         = (|vc_full) || inj_full;
endmodule
